regfile_dump: RTL and testbench

//  Debug read-out engine for the CPU register file. On a start pulse it walks

---
 rtl/regfile_dump_if.sv | 46 ++++
 rtl/regfile_dump.sv | 134 +++++++++++++
 tb/tb_regfile_dump.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Streaming output port of regfile_dump (valid/ready word stream to the debug/trace path).
// out_idx and the COUNT_BITS parameter exist only when REGFILE_DUMP_IDX_EN is defined.
interface regfile_dump_if #(
   parameter int unsigned WORD_SIZE = 8
`ifdef REGFILE_DUMP_IDX_EN
   , parameter int unsigned COUNT_BITS = 3
`endif
);
   logic [WORD_SIZE-1:0]  out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
`ifdef REGFILE_DUMP_IDX_EN
   logic [COUNT_BITS-1:0] out_idx;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      output out_idx,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      input  out_idx,
      output out_ready
   );
`else
   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
`endif
endinterface

// File: rtl/regfile_dump.sv
// Register-file debug dump: walks indices 0..COUNT-1 through one read port and streams the words.
// Optional feature macro: REGFILE_DUMP_IDX_EN adds out_idx to the stream interface.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef NUM_REGISTERS
`define NUM_REGISTERS 8
`endif

module regfile_dump #(
   parameter  int unsigned WORD_SIZE  = `WORD_SIZE,
   parameter  int unsigned COUNT      = `NUM_REGISTERS,
   localparam int unsigned COUNT_BITS = $clog2(COUNT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [COUNT_BITS-1:0] idx_read_o,
   input  logic [WORD_SIZE-1:0]  data_read_i,
   regfile_dump_if.master        out_if
);

   typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

   localparam logic [COUNT_BITS-1:0] LastIdx = COUNT_BITS'(COUNT - 1);

   state_e                state_q, state_d;
   logic [COUNT_BITS-1:0] idx_q, idx_d;
   logic [WORD_SIZE-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;
`ifdef REGFILE_DUMP_IDX_EN
   logic [COUNT_BITS-1:0] oidx_q, oidx_d;
`endif

   logic is_last;
   logic hs;

   assign is_last = (idx_q == LastIdx);
   assign hs      = valid_q && out_if.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StFetch;
         StFetch: state_d = StSend;
         StSend:  if (hs) state_d = is_last ? StIdle : StFetch;
         default: state_d = StIdle;
      endcase
   end

   // Output registers: the word is captured in FETCH and frozen for the whole SEND phase.
   always_comb begin
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = done_q;
`ifdef REGFILE_DUMP_IDX_EN
      oidx_d  = oidx_q;
`endif
      unique case (state_q)
         StIdle: begin
            done_d = 1'b0;
            if (start_i) idx_d = '0;
         end
         StFetch: begin
            data_d  = data_read_i;
            valid_d = 1'b1;
            last_d  = is_last;
`ifdef REGFILE_DUMP_IDX_EN
            oidx_d  = idx_q;
`endif
         end
         StSend: begin
            if (hs) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (is_last) begin
                  idx_d  = '0;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + COUNT_BITS'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef REGFILE_DUMP_IDX_EN
         oidx_q  <= '0;
`endif
      end else begin
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
`ifdef REGFILE_DUMP_IDX_EN
         oidx_q  <= oidx_d;
`endif
      end
   end

   assign busy_o           = (state_q != StIdle);
   assign done_o           = done_q;
   assign idx_read_o       = idx_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_last  = last_q;
`ifdef REGFILE_DUMP_IDX_EN
   assign out_if.out_idx   = oidx_q;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected words are queued at start and popped by a monitor.
// Register file is modelled as a plain array; writes during a dump patch not-yet-fetched entries.
module tb_regfile_dump;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 8;
   localparam int unsigned NB = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          busy_o;
   logic          done_o;
   logic [NB-1:0] idx_read_o;
   logic [W-1:0]  data_read_i;

`ifdef REGFILE_DUMP_IDX_EN
   regfile_dump_if #(.WORD_SIZE(W), .COUNT_BITS(NB)) sif ();
`else
   regfile_dump_if #(.WORD_SIZE(W)) sif ();
`endif

   regfile_dump #(.WORD_SIZE(W), .COUNT(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .idx_read_o  (idx_read_o),
      .data_read_i (data_read_i),
      .out_if      (sif)
   );

   always #5 clk = ~clk;

   logic [W-1:0] regs [N];
   assign data_read_i = regs[idx_read_o];

   typedef struct {
      logic [W-1:0] data;
      int           idx;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] got [N];
   int           errors = 0;
   int           checks = 0;
   int           acc_cnt = 0;
   int           done_cnt = 0;
   bit           expect_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, compares the presented word against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("done", 32'(done_o), 32'(expect_done));
         if (done_o) done_cnt++;
         expect_done = 1'b0;
         if (sif.out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected valid", 32'(sif.out_valid), 32'd0);
            end else begin
               chk("data", 32'(sif.out_data), 32'(q[0].data));
               chk("last", 32'(sif.out_last), 32'(q[0].idx == N - 1));
`ifdef REGFILE_DUMP_IDX_EN
               chk("out_idx", 32'(sif.out_idx), 32'(q[0].idx));
`endif
               if (sif.out_ready) begin
                  got[q[0].idx] = sif.out_data;
                  if (q[0].idx == N - 1) expect_done = 1'b1;
                  void'(q.pop_front());
                  acc_cnt++;
               end
            end
         end
      end
   end

   // Only entries behind the presented word are still unfetched.
   task automatic wr(input int k, input logic [W-1:0] v);
      regs[k] = v;
      if (q.size() > 0 && sif.out_valid)
         for (int i = 1; i < q.size(); i++)
            if (q[i].idx == k) q[i].data = v;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " busy"}, 32'(busy_o), 32'd0);
      chk({tag, " valid"}, 32'(sif.out_valid), 32'd0);
      chk({tag, " data"}, 32'(sif.out_data), 32'd0);
      chk({tag, " last"}, 32'(sif.out_last), 32'd0);
      chk({tag, " done"}, 32'(done_o), 32'd0);
      chk({tag, " idx_read"}, 32'(idx_read_o), 32'd0);
`ifdef REGFILE_DUMP_IDX_EN
      chk({tag, " out_idx"}, 32'(sif.out_idx), 32'd0);
`endif
   endtask

   // policy: 0 ready held high, 1 random ready. wr_mode: 0 none, 1 random, 2 directed r5/r1.
   task automatic run(input int policy, input int stall_at, input int restart_at,
                      input int abort_at, input int wr_mode, output int bc);
      int cyc;
      int stall_left;
      bit w5, w1, restarted;
      bc = 0; cyc = 0; stall_left = 5; w5 = 0; w1 = 0; restarted = 0;
      acc_cnt = 0;
      for (int i = 0; i < N; i++) q.push_back('{data: regs[i], idx: i});
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      while (busy_o && cyc < 400) begin
         bc++;
         start_i = 1'b0;
         sif.out_ready = (policy == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (stall_at >= 0 && stall_left > 0 && acc_cnt == stall_at && sif.out_valid) begin
            sif.out_ready = 1'b0;
            stall_left--;
            chk("stall idx_read", 32'(idx_read_o), 32'(stall_at));
         end
         if (!restarted && acc_cnt == restart_at && sif.out_valid) begin
            start_i = 1'b1;
            restarted = 1'b1;
         end
         if (wr_mode == 1 && sif.out_valid && $urandom_range(0, 3) == 0)
            wr($urandom_range(0, N - 1), W'($urandom));
         if (wr_mode == 2 && sif.out_valid && !w5 && acc_cnt == 2) begin
            wr(5, 8'hAA); w5 = 1;
         end
         if (wr_mode == 2 && sif.out_valid && !w1 && acc_cnt == 3) begin
            wr(1, 8'hBB); w1 = 1;
         end
         if (acc_cnt == abort_at && sif.out_valid) begin
            #2 rst_n = 1'b0;
            #1 chk_idle_outputs("async reset");
            q.delete();
            expect_done = 1'b0;
            @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            cyc = 0;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start_i = 1'b0;
      if (cyc >= 400) chk("dump timeout", 32'd1, 32'd0);
   endtask

   task automatic settle_and_check(input int d0, input int dumps);
      repeat (2) begin @(posedge clk); #1; end
      chk("queue drained", 32'(q.size()), 32'd0);
      chk("done pulses", 32'(done_cnt - d0), 32'(dumps));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      int d0;
      for (int i = 0; i < N; i++) regs[i] = W'(8'h10 + i);
      sif.out_ready = 1'b0;
      #3 chk_idle_outputs("reset");
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // Full dump, then a back-to-back start landing in the done cycle.
      d0 = done_cnt;
      run(0, -1, -1, -1, 0, bc);
      chk("busy cycles", 32'(bc), 32'd16);
      run(0, -1, -1, -1, 0, bc);
      chk("busy cycles b2b", 32'(bc), 32'd16);
      settle_and_check(d0, 2);

      // Five-cycle stall on r3.
      d0 = done_cnt;
      run(0, 3, -1, -1, 0, bc);
      chk("busy cycles stall", 32'(bc), 32'd21);
      settle_and_check(d0, 1);

      // start while busy at r2, then at the final SEND.
      d0 = done_cnt;
      run(0, -1, 2, -1, 0, bc);
      settle_and_check(d0, 1);
      d0 = done_cnt;
      run(0, -1, N - 1, -1, 0, bc);
      settle_and_check(d0, 1);

      // Reset mid-dump at r4, then a fresh dump from r0.
      d0 = done_cnt;
      run(0, -1, -1, 4, 0, bc);
      repeat (2) begin @(posedge clk); #1; end
      chk("no done after abort", 32'(done_cnt - d0), 32'd0);
      chk_idle_outputs("post abort");
      run(0, -1, -1, -1, 0, bc);
      settle_and_check(d0, 1);
      chk("restart streams r0", 32'(got[0]), 32'h10);

      // Writes during the dump.
      d0 = done_cnt;
      run(1, -1, -1, -1, 2, bc);
      settle_and_check(d0, 1);
      chk("r5 new value", 32'(got[5]), 32'hAA);
      chk("r1 old value", 32'(got[1]), 32'h11);

      // Randomized dumps.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < N; i++) regs[i] = W'($urandom);
         d0 = done_cnt;
         run(1, -1, -1, -1, 1, bc);
         settle_and_check(d0, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
